// File: rtl/alu_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_pkg
//  Description : Shared opcode and state encodings for the accumulator stage
//                and anything that drives it.
//  Contents    : OP_* opcode constants (3 bits), state_t FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_acc_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mul_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mul_nbit
//  Description : Unsigned N x N shift-add multiplier, one multiplier bit per
//                clock, LSB first.
//  Ports       : clk, rst_n  - clock / async active-low reset
//                start       - latch a, b and begin (ignored handshake-wise;
//                              the parent only asserts it when idle)
//                a, b        - multiplicand, multiplier (N bits)
//                busy        - multiply in progress
//                done        - high during the cycle whose closing edge
//                              processes the last multiplier bit
//                product     - 2N-bit product including the bit processed on
//                              the current edge; final when done is high
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_nbit #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [2*N-1:0]   r_prod;

  logic [2*N-1:0]   w_partial;
  logic [2*N-1:0]   w_prod_next;

  assign w_partial   = r_mplier[0] ? r_mcand : '0;
  assign w_prod_next = r_prod + w_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CNT_W'(N - 1);
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
    end else if (r_busy) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy    = r_busy;
  // Combinational so the parent can capture the result on the same edge that
  // consumes the last multiplier bit (no extra cycle of latency).
  assign done    = r_busy && (r_cnt == '0);
  assign product = w_prod_next;

endmodule
`default_nettype wire

// File: rtl/alu_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_stage
//  Description : Registered accumulator stage. Applies one opcode per
//                accepted transaction against an N-bit accumulator; MUL runs
//                on a sequential shift-add multiplier. Results and flags are
//                offered over a valid/ready handshake.
//  Ports       : clk, rst_n            - clock / async active-low reset
//                in_valid, in_ready    - input handshake (in_ready = IDLE)
//                operand, op           - operand and 3-bit opcode
//                out_valid, out_ready  - output handshake
//                acc                   - registered accumulator
//                zero, carry, overflow - registered result flags
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_stage
  import alu_acc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] operand,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] acc,
  output logic         zero,
  output logic         carry,
  output logic         overflow
);

  state_t         r_state;
  state_t         w_state_next;

  logic [N-1:0]   r_acc;
  logic           r_zero;
  logic           r_carry;
  logic           r_overflow;
  logic           r_out_valid;

  logic           w_accept;
  logic           w_mul_start;
  logic           w_complete;
  logic [N-1:0]   w_acc_next;
  logic           w_carry_next;
  logic           w_overflow_next;

  logic [N:0]     w_sum;
  logic [N:0]     w_diff;

  logic           w_mul_busy;
  logic           w_mul_done;
  logic [2*N-1:0] w_mul_product;

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (op == OP_MUL);

  seq_mul_nbit #(
    .N (N)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (r_acc),
    .b       (operand),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op == OP_MUL) begin
            w_state_next = ST_MUL;
          end else begin
            w_state_next = ST_RESP;
            w_complete   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_next = ST_RESP;
          w_complete   = 1'b1;
        end else if (!w_mul_busy) begin
          // Multiplier lost its job without finishing; recover to idle.
          w_state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: result and flags for whichever op completes this edge
  // --------------------------------------------------------------------------
  assign w_sum  = {1'b0, r_acc} + {1'b0, operand};
  assign w_diff = {1'b0, r_acc} - {1'b0, operand};

  always_comb begin
    w_acc_next      = r_acc;
    w_carry_next    = 1'b0;
    w_overflow_next = 1'b0;
    if (r_state == ST_MUL) begin
      w_acc_next   = w_mul_product[N-1:0];
      w_carry_next = |w_mul_product[2*N-1:N];
    end else begin
      case (op)
        OP_LOAD: w_acc_next = operand;
        OP_ADD: begin
          w_acc_next      = w_sum[N-1:0];
          w_carry_next    = w_sum[N];
          w_overflow_next = (r_acc[N-1] == operand[N-1]) &&
                            (w_sum[N-1] != r_acc[N-1]);
        end
        OP_SUB: begin
          w_acc_next      = w_diff[N-1:0];
          // Top bit of the widened difference is the unsigned borrow.
          w_carry_next    = w_diff[N];
          w_overflow_next = (r_acc[N-1] != operand[N-1]) &&
                            (w_diff[N-1] != r_acc[N-1]);
        end
        OP_AND:  w_acc_next = r_acc & operand;
        OP_OR:   w_acc_next = r_acc | operand;
        OP_XOR:  w_acc_next = r_acc ^ operand;
        OP_CLR:  w_acc_next = '0;
        default: w_acc_next = r_acc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == ST_RESP);
      if (w_complete) begin
        r_acc      <= w_acc_next;
        r_zero     <= (w_acc_next == '0);
        r_carry    <= w_carry_next;
        r_overflow <= w_overflow_next;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign acc       = r_acc;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_acc_stage
//  Description : Directed self-checking bench for alu_acc_stage (N = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_acc_stage;
  import alu_acc_pkg::*;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] operand;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc;
  logic         zero;
  logic         carry;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  alu_acc_stage #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand   (operand),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one transaction while idle; returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [N-1:0] d);
    in_valid = 1'b1;
    op       = o;
    operand  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid after a MUL accept; reports cycles and whether
  // in_ready was ever seen high while waiting.
  task automatic wait_resp(output int cycles, output logic ready_seen);
    cycles     = 0;
    ready_seen = 1'b0;
    while (!out_valid && cycles < 20) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      cycles++;
    end
  endtask

  int   cyc;
  logic rdy_seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operand   = '0;
    op        = OP_LOAD;
    out_ready = 1'b1;
    #12;
    check("rst_acc",       acc,       8'h00);
    check("rst_zero",      zero,      1'b0);
    check("rst_flags",     {carry, overflow}, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    rst_n = 1'b1;
    tick();

    // LOAD 0x80 ; ADD 0x80 -> 0x00, zero/carry/overflow set
    send(OP_LOAD, 8'h80);
    check("load80_valid", {out_valid, in_ready}, 2'b10);
    check("load80_acc", acc, 8'h80);
    tick();
    check("load80_ack", {out_valid, in_ready}, 2'b01);
    send(OP_ADD, 8'h80);
    check("add_acc", acc, 8'h00);
    check("add_zco", {zero, carry, overflow}, 3'b111);
    tick();

    // LOAD 0x01 ; SUB 0x02 -> 0xFF, borrow, no overflow
    send(OP_LOAD, 8'h01);
    check("load01_flags", {zero, carry, overflow}, 3'b000);
    tick();
    send(OP_SUB, 8'h02);
    check("sub_acc", acc, 8'hFF);
    check("sub_zco", {zero, carry, overflow}, 3'b010);
    tick();

    // LOAD 0x03 ; MUL 0x04 -> 0x0C after exactly 8 cycles
    send(OP_LOAD, 8'h03);
    tick();
    send(OP_MUL, 8'h04);
    wait_resp(cyc, rdy_seen);
    check("mul1_latency", 16'(cyc), 16'd8);
    check("mul1_inready_low", rdy_seen, 1'b0);
    check("mul1_acc", acc, 8'h0C);
    check("mul1_zco", {zero, carry, overflow}, 3'b000);
    tick();

    // LOAD 0x20 ; MUL 0x10 -> 0x200: low byte 0, high part nonzero
    send(OP_LOAD, 8'h20);
    tick();
    send(OP_MUL, 8'h10);
    wait_resp(cyc, rdy_seen);
    check("mul2_latency", 16'(cyc), 16'd8);
    check("mul2_acc", acc, 8'h00);
    check("mul2_zco", {zero, carry, overflow}, 3'b110);
    tick();

    // Backpressure: ADD 0x04 onto 0, CLR requests must be ignored
    out_ready = 1'b0;
    send(OP_ADD, 8'h04);
    check("bp_acc0", acc, 8'h04);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op       = OP_CLR;
      tick();
      check("bp_hold", {out_valid, in_ready, acc, zero, carry, overflow},
            {1'b1, 1'b0, 8'h04, 3'b000});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {out_valid, in_ready, acc}, {1'b0, 1'b1, 8'h04});

    // Reset mid-multiply
    send(OP_LOAD, 8'h40);
    tick();
    send(OP_MUL, 8'h02);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_acc", acc, 8'h00);
    check("mrst_flags", {zero, carry, overflow}, 3'b000);
    check("mrst_hs", {out_valid, in_ready}, 2'b01);
    #2;
    rst_n = 1'b1;
    tick();
    check("mrst_idle", {out_valid, in_ready, acc}, {1'b0, 1'b1, 8'h00});
    send(OP_LOAD, 8'h05);
    check("post_rst_load", {out_valid, acc}, {1'b1, 8'h05});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_acc_stage.md
# alu_acc_stage

Registered accumulator stage directly downstream of the N-bit 4-input operand mux. It consumes the mux output `y` as its operand and applies one opcode per transaction against an internal N-bit accumulator. Single-cycle ops cover load, add, sub and logic; multiply is a multi-cycle shift-add. Results and flags are presented over a valid/ready handshake to the next consumer.

## Interface
- `N`, default 8: operand, accumulator and result width.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous reset, active-low. Single clock domain.
- `in_valid` input 1: operand/opcode present.
- `in_ready` output 1: stage can accept. Equals (state == IDLE).
- `operand` input N: operand, driven from mux output `y`.
- `op` input 3: opcode. 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 CLR.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer accepts result.
- `acc` output N: accumulator value, registered.
- `zero` output 1: `acc == 0` after the last completed op.
- `carry` output 1: carry, borrow or multiply high-part flag.
- `overflow` output 1: signed overflow for ADD and SUB.

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - MUL: multiply in progress.
  - RESP: `out_valid` = 1.
- Acceptance: `in_valid && in_ready` at a rising edge. `op` and `operand` are sampled only at that edge.
- Single-cycle ops complete on the accepting edge, then IDLE→RESP.
  - LOAD: acc = operand.
  - CLR: acc = 0.
  - AND / OR / XOR: acc = acc op operand.
  - LOAD, CLR, AND, OR, XOR: carry = 0, overflow = 0.
- ADD:
  - acc = (acc + operand) mod 2^N.
  - carry = bit N of the (N+1)-bit sum.
  - overflow = operands have the same sign and the result sign differs.
- SUB:
  - acc = (acc − operand) mod 2^N.
  - carry = borrow, i.e. 1 iff acc < operand unsigned.
  - overflow = operands have different signs and the result sign differs from the old acc.
- MUL (unsigned):
  - On the accepting edge: IDLE→MUL. Latch multiplicand = acc and multiplier = operand, clear the 2N-bit product, bit counter = N−1.
  - Each MUL edge processes one multiplier bit, LSB first.
  - On the edge where counter == 0:
    - acc = product[N−1:0].
    - carry = |product[2N−1:N].
    - overflow = 0.
    - State → RESP.
- zero is recomputed from the new acc on every completing edge.
- RESP: `out_valid && out_ready` at an edge → IDLE. `acc` and flags hold until the next op completes.
- `in_valid` is ignored outside IDLE. No queuing and no pass-through.
- Reset (`rst_n` low, any time, including mid-MUL):
  - State = IDLE.
  - acc, zero, carry, overflow = 0. The zero flag register resets to 0, even though acc = 0.
  - `out_valid` = 0; `in_ready` = 1.
  - Any in-progress multiply is discarded.

## Timing
- Single-cycle op accepted at edge E: `out_valid` rises after E, with acc and flags updated at E. Latency is 1 cycle.
- MUL accepted at edge E: N MUL edges, then `out_valid` rises after edge E+N.
- Throughput, single-cycle ops:
  - With `out_ready` held high, one op per 2 cycles (accept, respond).
  - Back-to-back acceptance is not required.
- Backpressure: RESP holds indefinitely. `out_valid`, `acc` and flags stay stable. `in_ready` = 0.
- All outputs are registered except `in_ready`, which is decoded from state.
- No combinational path from `in_valid`, `op` or `operand` to any output.

## Structure
- Package `alu_acc_pkg`:
  - Opcode localparams (OP_LOAD…OP_CLR).
  - State encoding (ST_IDLE, ST_MUL, ST_RESP).
  - Shared by the bench for stimulus.
- One sub-module, `seq_mul_nbit`:
  - Parameter N.
  - Ports: `start`, `a`, `b`, `busy`, `done`, `product[2N−1:0]`.
  - Shift-add with internal counter.
  - `done` pulses on the final edge.
  - Uses the same `clk`/`rst_n` as the parent.
- Parent holds the FSM, flag logic and add/sub/logic datapath.

## Test plan
All scenarios use N = 8.
- LOAD 0x80, then ADD 0x80 → acc 0x00, zero 1, carry 1, overflow 1.
- LOAD 0x01, then SUB 0x02 → acc 0xFF, carry 1, overflow 0, zero 0.
- LOAD 0x03, then MUL 0x04 → `out_valid` exactly 8 cycles after MUL acceptance, acc 0x0C, carry 0. `in_ready` low throughout.
- LOAD 0x20, then MUL 0x10 (product 0x200) → acc 0x00, carry 1, zero 1.
- ADD 0x04 accepted with `out_ready` low for 5 cycles while `in_valid` toggles with op CLR → `out_valid`, acc and flags stable; CLR not accepted; IDLE on the first `out_ready` edge.
- LOAD 0x40, start MUL 0x02, assert `rst_n` low after 3 MUL cycles → acc 0, all flags 0, `out_valid` 0, `in_ready` 1. After release, LOAD 0x05 → acc 0x05 one cycle later.
